// File: rtl/iter_int_mul.sv
// Iterative signed 32x32->64 multiplier: one operand pair in flight, shift-and-add core.
// Define ITER_INT_MUL_RADIX4_EN to retire 2 multiplier bits per cycle (L=16 instead of 32).
module iter_int_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] intA,
    input  logic [31:0] intB,
    input  logic        val_op,
    output logic        oprand_rdy,
    output logic [63:0] longP,
    output logic        commit,
    output logic [1:0]  dbg_state
);

`ifdef ITER_INT_MUL_RADIX4_EN
    localparam int CW = 4;
`else
    localparam int CW = 5;
`endif
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [63:0]   mcand, acc, acc_next, pp, mcand_sh;
    logic [31:0]   mplier, mplier_sh, a_abs, b_abs;
    logic [CW-1:0] cnt;
    logic          neg, accept, last;

    // Valid/ready: a pair transfers on a rising edge where val_op and oprand_rdy
    // are both high; the source holds intA/intB/val_op stable until then.
    assign oprand_rdy = (state != BUSY);
    assign accept     = val_op && oprand_rdy;
    assign last       = (state == BUSY) && (cnt == CNT_LAST);
    assign dbg_state  = state;

    assign a_abs = intA[31] ? (~intA + 32'd1) : intA;
    assign b_abs = intB[31] ? (~intB + 32'd1) : intB;

    always_comb begin
        pp = 64'd0;
`ifdef ITER_INT_MUL_RADIX4_EN
        case (mplier[1:0])
            2'd0: pp = 64'd0;
            2'd1: pp = mcand;
            2'd2: pp = mcand << 1;
            2'd3: pp = mcand + (mcand << 1);
            default: pp = 64'd0;
        endcase
        mplier_sh = mplier >> 2;
        mcand_sh  = mcand << 2;
`else
        if (mplier[0]) pp = mcand;
        mplier_sh = mplier >> 1;
        mcand_sh  = mcand << 1;
`endif
        acc_next = acc + pp;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last) state_next = DONE;
            DONE:    state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= 64'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            cnt    <= '0;
            neg    <= 1'b0;
            longP  <= 64'd0;
            commit <= 1'b0;
        end else begin
            commit <= last;
            if (accept) begin
                mcand  <= {32'd0, a_abs};
                mplier <= b_abs;
                acc    <= 64'd0;
                cnt    <= '0;
                neg    <= intA[31] ^ intB[31];
            end else if (state == BUSY) begin
                acc    <= acc_next;
                mplier <= mplier_sh;
                mcand  <= mcand_sh;
                // Hold at terminal count rather than wrap.
                if (!last) cnt <= cnt + 1'b1;
            end
            if (last) longP <= neg ? (~acc_next + 64'd1) : acc_next;
        end
    end

endmodule

// File: doc/iter_int_mul.md
# iter_int_mul

Iterative signed 32×32→64 integer multiplier. It is the responder on the same `val_op`/`oprand_rdy`/`commit` operand/result handshake that the pipelined multiplier's stimulus source and checker drive. It trades throughput for area: one operand pair is in flight at a time, retiring 1 multiplier bit per cycle (or 2 with radix-4). It slots into any datapath or bench in place of the pipelined unit.

## Interface
- Parameters: none; width fixed at 32-bit operands, 64-bit product.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset. 0 = reset.
- `intA` input 32: multiplicand, two's complement.
- `intB` input 32: multiplier, two's complement.
- `val_op` input 1: operand pair valid.
- `oprand_rdy` output 1: block can accept an operand pair this cycle.
- `longP` output 64: signed product, held until next commit.
- `commit` output 1: one-cycle pulse; `longP` valid in this cycle.

## Operation
- States:
  - IDLE: `oprand_rdy`=1.
  - BUSY: `oprand_rdy`=0.
  - DONE: `oprand_rdy`=1, `commit`=1.
- Accept: at a rising edge with `val_op`=1 and `oprand_rdy`=1.
  - Latch |intA| and |intB| as 32-bit unsigned; |−2^31| = 0x80000000.
  - Latch `neg` = intA[31]^intB[31].
  - Clear the 64-bit accumulator and iteration counter; go to BUSY.
- BUSY, per cycle:
  - If the multiplier LSB is set, add the shifted multiplicand to the accumulator.
  - Shift the multiplier right and the multiplicand left; increment the counter.
- Last iteration edge: load `longP` = `neg` ? −acc_next : acc_next (64-bit two's complement); go to DONE.
- DONE:
  - With `val_op`=1: accept the new pair (back-to-back) and go to BUSY.
  - Otherwise go to IDLE.
- While not accepting, `val_op` and operands are ignored. The source holds its pair until `oprand_rdy`=1.
- The counter never wraps. The BUSY exit is decoded at terminal count.
- Zero operands still take the full latency; there is no early termination.

## Timing
- Reset values: state IDLE, `commit`=0, `longP`=0, `oprand_rdy`=1. Accumulator and counter are cleared.
- Reset asserted mid-BUSY or in DONE: the operation is aborted immediately with no commit. The first accept is possible on the first edge after release.
- Latency L = 32 cycles (16 with radix-4).
  - Accept at edge E0 → `commit`=1 in the cycle following edge E_L.
- Throughput: one result per L+1 cycles when `val_op` is held high. The accept in DONE overlaps the commit cycle.
- `commit` and `longP` are registered; no combinational path from the inputs.
- `oprand_rdy` is decoded from registered state only.

## Configuration
- `ITER_INT_MUL_RADIX4_EN` defined:
  - Radix-4 iteration: 2 multiplier bits per cycle.
  - Partial-product add of 0, M, 2M or 3M.
  - Counter counts 0..15, L=16.
- Undefined: radix-2, L=32.
- Interface, reset behaviour, sign handling and handshake are identical in both builds.

## Test plan
- Reset release, then intA=3, intB=4, `val_op` pulse → `oprand_rdy`=0 for L cycles, then `commit` one cycle with `longP`=0x000000000000000C. Afterwards `oprand_rdy`=1 and `longP` is held.
- intA=−7 (0xFFFFFFF9), intB=5 → `longP`=0xFFFFFFFFFFFFFFDD. intA=intB=0xFFFFFFFF → `longP`=1.
- intA=intB=0x80000000 → `longP`=0x4000000000000000. intA=0x80000000, intB=0x7FFFFFFF → `longP`=0xC000000080000000.
- `val_op` held high with 3 queued pairs (2×3, −1×8, 0×0x7FFFFFFF) → commits exactly L+1 cycles apart with 6, 0xFFFFFFFFFFFFFFF8, 0.
- During BUSY, change intA/intB and toggle `val_op` → product reflects the originally accepted pair; no extra commit.
- Assert `reset` 10 cycles into BUSY → `commit`=0, `longP`=0 and `oprand_rdy`=1 asynchronously. After release, 5×5 commits 25 at latency L.
